// File: rtl/run_sequencer.sv
// run_sequencer: owns one program run of the accumulator CPU.
//   IDLE -> (go) LOAD -> (last beat) START -> RUN -> (halt) DONE -> (go) LOAD
// During LOAD the loader drives the DataRAM write port through mem_*.
// START holds cpu_start for START_CYCLES cycles, and RUN counts core cycles until halt.
// Optional feature macro: WATCHDOG_EN. When it is defined, RUN also ends once
// cycle_count reaches MAX_CYCLES, and timeout is set.
//
// Loader handshake: a beat transfers on a rising CLK edge where ld_valid and
// ld_ready are both high. ld_ready depends only on the state (high in LOAD)
// and never on ld_valid. The loader holds its beat stable until it transfers.

module run_sequencer #(
  parameter int          AW           = 8,
  parameter int          DW           = 8,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          go,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          cpu_start,
  input  logic          cpu_halt,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   cycle_count,
  output logic [AW:0]   load_count,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam logic [3:0]  START_LAST = 4'(START_CYCLES - 1);
  localparam logic [AW:0] LOAD_MAX   = {1'b1, {AW{1'b0}}};

  state_t      state, state_nx;
  logic [3:0]  start_cnt;
  logic        timeout_q;
  logic        accept;
  logic        launch;
  logic        wd_hit;
  logic [15:0] cc_inc;

  // A beat transfers only while loading. This is written directly from state so that it does not loop through ld_ready.
  assign accept = ld_valid && (state == S_LOAD);
  // go is honoured only while parked in IDLE or DONE.
  assign launch = go && ((state == S_IDLE) || (state == S_DONE));
  // The cycle counter sticks at all-ones.
  assign cc_inc = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
  // The watchdog fires on the RUN cycle that brings the count to the limit. A halt in that same cycle takes priority.
  assign wd_hit = WD_EN && (state == S_RUN) && !cpu_halt && (cc_inc == MAX_CYCLES);

  assign timeout   = timeout_q;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx  = state;
    ld_ready  = 1'b0;
    cpu_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nx = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (accept && ld_last) state_nx = S_START;
      end
      S_START: begin
        cpu_start = 1'b1;
        busy      = 1'b1;
        if (start_cnt == START_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cpu_halt || wd_hit) state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (go) state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Count the cycles spent in START. The count is held at zero outside START so that each entry begins fresh.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 start_cnt <= 4'd0;
    else if (state != S_START)  start_cnt <= 4'd0;
    else                        start_cnt <= start_cnt + 4'd1;
  end

  // Loader-side write port: register each accepted beat. mem_sel trails state by one cycle so that it covers the final write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_sel   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_sel <= (state == S_LOAD);
      mem_we  <= accept;
      if (accept) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_data;
      end
    end
  end

  // Run statistics. They are cleared when a run launches, and otherwise they persist until the next go.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_count <= 16'd0;
      load_count  <= '0;
      timeout_q   <= 1'b0;
    end else if (launch) begin
      cycle_count <= 16'd0;
      load_count  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (accept && (load_count != LOAD_MAX)) load_count <= load_count + 1'b1;
      if (state == S_RUN)                     cycle_count <= cc_inc;
      if (wd_hit)                             timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer. A timeline model records the clock-edge index of each
// event (go, accepted beats, last beat, end of run). It derives every output
// from those timestamps with plain arithmetic. A write scoreboard holds the hand-written beats.
// Reacts to WATCHDOG_EN in the same way as the design (MAX_CYCLES = 8 here).

module tb_run_sequencer;
  localparam int          AW   = 8;
  localparam int          DW   = 8;
  localparam int          S    = 2;
  localparam logic [15:0] MAXC = 16'd8;
  localparam longint      INF  = 64'd1 << 40;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          go = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          cpu_start;
  logic          cpu_halt = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [15:0]   cycle_count;
  logic [AW:0]   load_count;
  logic [2:0]    state_dbg;

  run_sequencer #(.AW(AW), .DW(DW), .START_CYCLES(S), .MAX_CYCLES(MAXC)) dut (
    .CLK(CLK), .RST_N(RST_N), .go(go), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_start(cpu_start),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .load_count(load_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int we_seen = 0;
  int start_seen = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  longint cyc = 0;          // index of the most recent rising edge
  longint m_g, m_l, m_e;    // edge of go, of the last beat, and of the end of the run
  longint m_acc_edge;       // edge of the most recent accepted beat
  int     m_acc_cnt;
  bit     m_to;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_g = INF; m_l = INF; m_e = INF; m_acc_edge = -1;
    m_acc_cnt = 0; m_to = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // Apply the inputs seen at edge n. Phases are derived from the timestamps at edge n-1.
  task automatic model_step(input longint n);
    longint p;
    bit idle_done, in_load, in_run;
    p = n - 1;
    idle_done = (m_g == INF) || (p >= m_e);
    in_load   = (m_g != INF) && (p >= m_g) && (p < m_l);
    in_run    = (m_l != INF) && (p >= m_l + S) && (p < m_e);
    if (idle_done && go) begin
      m_g = n; m_l = INF; m_e = INF; m_acc_cnt = 0; m_to = 1'b0;
    end else if (in_load && ld_valid) begin
      m_acc_edge = n; m_addr = ld_addr; m_data = ld_data;
      if (m_acc_cnt < (1 << AW)) m_acc_cnt++;
      if (ld_last) m_l = n;
    end else if (in_run) begin
      if (cpu_halt) m_e = n;
`ifdef WATCHDOG_EN
      else if (n - (m_l + S) == longint'(MAXC)) begin
        m_e = n; m_to = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_cycle(input longint n);
    bit e_busy, e_done, e_ready, e_start, e_sel, e_we;
    longint e_cc;
    logic [AW+DW-1:0] e_wr;
    e_busy  = (m_g != INF) && (n >= m_g) && (n < m_e);
    e_done  = (m_g != INF) && (n >= m_e);
    e_ready = (m_g != INF) && (n >= m_g) && (n < m_l);
    e_start = (m_l != INF) && (n >= m_l) && (n < m_l + S);
    e_sel   = (m_g != INF) && (n > m_g) && (n <= m_l);
    e_we    = (n == m_acc_edge);
    e_cc = 0;
    if ((m_l != INF) && (n >= m_l + S)) begin
      e_cc = ((n < m_e) ? n : m_e) - (m_l + S);
      if (e_cc > 65535) e_cc = 65535;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("ld_ready", ld_ready, e_ready);
    chk("cpu_start", cpu_start, e_start);
    chk("mem_sel", mem_sel, e_sel);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_data);
    chk("cycle_count", cycle_count, e_cc);
    chk("load_count", load_count, m_acc_cnt);
    chk("timeout", timeout, m_to);
    chk("busy_done_excl", busy & done, 0);
    if (cpu_start === 1'b1) start_seen++;
    if (mem_we === 1'b1) begin
      we_seen++;
      chk("we_needs_sel", mem_sel, 1);
      chk("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e_wr = exp_q.pop_front();
        chk("wr_beat", {mem_addr, mem_wdata}, e_wr);
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
    if (RST_N !== 1'b1) model_reset();
    else model_step(cyc);
  end

  initial forever begin
    @(negedge RST_N);
    model_reset();
  end

  // Compare process: one check per cycle, 1 time unit after the edge.
  initial forever begin
    @(posedge CLK);
    #1;
    if (RST_N === 1'b1) check_cycle(cyc);
  end

  // ---------------- driver tasks (called just after a falling edge) ----------------
  task automatic idle(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last, input bit expect_wr);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    if (expect_wr) exp_q.push_back({a, d});
    @(negedge CLK);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, ".ld_ready"}, ld_ready, 0);
    chk({tag, ".mem_sel"}, mem_sel, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".cpu_start"}, cpu_start, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".timeout"}, timeout, 0);
    chk({tag, ".cycle_count"}, cycle_count, 0);
    chk({tag, ".load_count"}, load_count, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    idle(3);
    zero_outs("reset");
    RST_N = 1'b1;
    idle(2);

    // Run 1: gapped preload, with go during LOAD and RUN, and a halt pulse during START. The halt lands on RUN cycle 5.
    we_seen = 0; start_seen = 0;
    pulse_go();
    beat(8'h10, 8'hAA, 1'b0, 1'b1);
    go = 1'b1; @(negedge CLK); go = 1'b0; @(negedge CLK);
    beat(8'h11, 8'hBB, 1'b0, 1'b1);
    idle(2);
    beat(8'h12, 8'hCC, 1'b1, 1'b1);
    cpu_halt = 1'b1; @(negedge CLK); cpu_halt = 1'b0;
    idle(2);
    go = 1'b1; @(negedge CLK); go = 1'b0;
    idle(2);
    cpu_halt = 1'b1; @(negedge CLK); cpu_halt = 1'b0;
    idle(2);
    chk("run1.done", done, 1);
    chk("run1.busy", busy, 0);
    chk("run1.cycle_count", cycle_count, 5);
    chk("run1.timeout", timeout, 0);
    chk("run1.load_count", load_count, 3);
    chk("run1.start_cycles", start_seen, 2);
    chk("run1.writes", we_seen, 3);

    // Run 2: go from DONE clears the stats. Four back-to-back beats follow, and halt is held so it lands on RUN cycle 1.
    we_seen = 0; start_seen = 0;
    pulse_go();
    chk("run2.done_cleared", done, 0);
    chk("run2.cc_cleared", cycle_count, 0);
    chk("run2.lc_cleared", load_count, 0);
    chk("run2.busy", busy, 1);
    cpu_halt = 1'b1;
    beat(8'h30, 8'h01, 1'b0, 1'b1);
    beat(8'h31, 8'h02, 1'b0, 1'b1);
    beat(8'h32, 8'h03, 1'b0, 1'b1);
    beat(8'h33, 8'h04, 1'b1, 1'b1);
    idle(4);
    cpu_halt = 1'b0;
    chk("run2.done", done, 1);
    chk("run2.cycle_count", cycle_count, 1);
    chk("run2.load_count", load_count, 4);
    chk("run2.writes", we_seen, 4);
    chk("run2.start_cycles", start_seen, 2);

`ifdef WATCHDOG_EN
    // Run 3: the core never halts, so the watchdog ends the run at 8 cycles.
    pulse_go();
    beat(8'h40, 8'h55, 1'b1, 1'b1);
    idle(12);
    chk("wd.done", done, 1);
    chk("wd.timeout", timeout, 1);
    chk("wd.cycle_count", cycle_count, 8);
    // Run 4: the halt lands on exactly the 8th cycle and wins over the watchdog.
    pulse_go();
    chk("wd.timeout_cleared", timeout, 0);
    beat(8'h41, 8'h66, 1'b1, 1'b1);
    idle(9);
    cpu_halt = 1'b1; @(negedge CLK); cpu_halt = 1'b0;
    idle(2);
    chk("wd_halt.done", done, 1);
    chk("wd_halt.timeout", timeout, 0);
    chk("wd_halt.cycle_count", cycle_count, 8);
`else
    // Run 3: with no watchdog, RUN keeps going well past 8 cycles.
    pulse_go();
    beat(8'h40, 8'h55, 1'b1, 1'b1);
    idle(32);
    chk("long.busy", busy, 1);
    chk("long.done", done, 0);
    chk("long.cycle_count", cycle_count, 30);
    cpu_halt = 1'b1; @(negedge CLK); cpu_halt = 1'b0;
    idle(1);
    chk("long_halt.done", done, 1);
    chk("long_halt.cycle_count", cycle_count, 31);
    chk("long_halt.timeout", timeout, 0);
`endif

    // Reset during LOAD, while the first beat's write is still visible. The beats that follow must not be taken.
    pulse_go();
    beat(8'h20, 8'h11, 1'b0, 1'b1);
    chk("mid_load.we_before", mem_we, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_load.ld_ready", ld_ready, 0);
    chk("mid_load.mem_we", mem_we, 0);
    chk("mid_load.mem_sel", mem_sel, 0);
    chk("mid_load.busy", busy, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    beat(8'h21, 8'h22, 1'b0, 1'b0);
    beat(8'h22, 8'h33, 1'b1, 1'b0);
    idle(3);
    chk("after_rst.load_count", load_count, 0);
    chk("after_rst.busy", busy, 0);

    // Reset in the middle of a cycle during RUN, with go held high through the reset.
    pulse_go();
    beat(8'h50, 8'h77, 1'b1, 1'b1);
    idle(4);
    chk("rst_run.busy_before", busy, 1);
    go = 1'b1;
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1 zero_outs("rst_run");
    @(posedge CLK);
    #1 zero_outs("rst_run_held");
    @(negedge CLK);
    go = 1'b0;
    RST_N = 1'b1;
    idle(3);
    chk("rst_run.stays_idle", busy, 0);
    chk("rst_run.no_done", done, 0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
